// File: rtl/ss_pkg.sv
// Shared definitions for the seven-segment display controller:
// segment codes (active-low {g,f,e,d,c,b,a}), converter states,
// digit count, BCD width and small decode helpers.
package ss_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int BCD_W      = 12;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   typedef logic [1:0] state_t;
   localparam state_t IDLE   = 2'd0;
   localparam state_t SHIFT  = 2'd1;
   localparam state_t COMMIT = 2'd2;

   // Maps a BCD digit to its segment pattern; non-decimal codes show nothing.
   function automatic logic [6:0] segDecode(input logic [3:0] digit);
      case (digit)
         4'd0:    segDecode = SEG_0;
         4'd1:    segDecode = SEG_1;
         4'd2:    segDecode = SEG_2;
         4'd3:    segDecode = SEG_3;
         4'd4:    segDecode = SEG_4;
         4'd5:    segDecode = SEG_5;
         4'd6:    segDecode = SEG_6;
         4'd7:    segDecode = SEG_7;
         4'd8:    segDecode = SEG_8;
         4'd9:    segDecode = SEG_9;
         default: segDecode = SEG_BLANK;
      endcase
   endfunction

   // Double-dabble correction: every BCD nibble of 5 or more gets 3 added
   // so that the following left shift carries correctly into the next digit.
   function automatic logic [BCD_W-1:0] dabbleAdjust(input logic [BCD_W-1:0] acc);
      logic [BCD_W-1:0] result;
      result = acc;
      for (int n = 0; n < BCD_W / 4; n++) begin
         if (acc[n*4 +: 4] >= 4'd5) begin
            result[n*4 +: 4] = acc[n*4 +: 4] + 4'd3;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/ss_bin2bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble).
// One shift step per clock; busy covers the 8 shift cycles plus the
// commit cycle, during which done is high and bcd holds the result.
module ss_bin2bcd
   import ss_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       value,
   output logic             busy,
   output logic             done,
   output logic [BCD_W-1:0] bcd
);

   state_t           state;
   logic [7:0]       shiftReg;
   logic [BCD_W-1:0] bcdAcc;
   logic [2:0]       bitCnt;
   logic [BCD_W-1:0] adjusted;

   assign adjusted = dabbleAdjust(bcdAcc);

   // Converter FSM: capture on start, eight adjust-and-shift steps, then one commit cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         shiftReg <= '0;
         bcdAcc   <= '0;
         bitCnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shiftReg <= value;
                  bcdAcc   <= '0;
                  bitCnt   <= '0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               {bcdAcc, shiftReg} <= {adjusted[BCD_W-2:0], shiftReg, 1'b0};
               bitCnt             <= bitCnt + 3'd1;
               if (bitCnt == 3'd7) begin
                  state <= COMMIT;
               end
            end
            COMMIT: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == COMMIT);
   assign bcd  = bcdAcc;

endmodule

// File: rtl/ss_display_ctrl.sv
// Four-digit time-multiplexed common-anode seven-segment controller.
// Captures a byte on load, converts it to BCD and shows it with optional
// leading-zero blanking. Build macro SS_SIGNED_EN treats data_in as two's
// complement and shows a minus sign on the leftmost digit.
module ss_display_ctrl
   import ss_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter bit LZ_BLANK    = 1'b1
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [7:0]            data_in,
   output logic                  busy,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg
);

   localparam int CNT_W = $clog2(REFRESH_DIV);

   logic             accept;
   logic             done;
   logic [7:0]       magnitude;
   logic [BCD_W-1:0] bcd;
   logic [3:0]       hundreds;
   logic [3:0]       tens;
   logic [3:0]       ones;
   logic             signReg;
   logic [CNT_W-1:0] refreshCnt;
   logic [1:0]       digitIdx;

   assign accept = load & ~busy;

`ifdef SS_SIGNED_EN
   logic pendingSign;

   assign magnitude = data_in[7] ? (~data_in + 8'd1) : data_in;

   // Sign is captured with the operand and only shown once its digits commit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pendingSign <= 1'b0;
         signReg     <= 1'b0;
      end else begin
         if (accept) begin
            pendingSign <= data_in[7];
         end
         if (done) begin
            signReg <= pendingSign;
         end
      end
   end
`else
   assign magnitude = data_in;
   assign signReg   = 1'b0;
`endif

   ss_bin2bcd bin2bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept),
      .value (magnitude),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

   // Displayed digits hold the last finished conversion until the next one commits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hundreds <= '0;
         tens     <= '0;
         ones     <= '0;
      end else if (done) begin
         hundreds <= bcd[11:8];
         tens     <= bcd[7:4];
         ones     <= bcd[3:0];
      end
   end

   // Free-running slot timer; each wrap moves the scan to the next digit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         refreshCnt <= '0;
         digitIdx   <= '0;
      end else if (refreshCnt == CNT_W'(REFRESH_DIV - 1)) begin
         refreshCnt <= '0;
         digitIdx   <= digitIdx + 2'd1;
      end else begin
         refreshCnt <= refreshCnt + CNT_W'(1);
      end
   end

   assign an = ~(NUM_DIGITS'(1) << digitIdx);

   // Segment pattern for the digit currently being scanned, with leading-zero blanking.
   always_comb begin
      seg = SEG_BLANK;
      case (digitIdx)
         2'd0: seg = segDecode(ones);
         2'd1: begin
            if (!(LZ_BLANK && hundreds == 4'd0 && tens == 4'd0)) begin
               seg = segDecode(tens);
            end
         end
         2'd2: begin
            if (!(LZ_BLANK && hundreds == 4'd0)) begin
               seg = segDecode(hundreds);
            end
         end
         2'd3: begin
            if (signReg) begin
               seg = SEG_MINUS;
            end
         end
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: doc/ss_display_ctrl.md
Name: ss_display_ctrl

Overview:
- Downstream consumer of the mini processor's seven-segment data output (ssOutput) and its strobe (ssCtrl).
- Captures an 8-bit value on a load strobe and converts it to BCD with a sequential double-dabble engine.
- Drives a 4-digit, time-multiplexed, common-anode seven-segment display with optional leading-zero blanking.
- Display keeps the last committed value until a new conversion completes.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit slot; must be >= 2.
- LZ_BLANK, 1: 1 = blank leading zeros in hundreds/tens; 0 = always show all three digits.

Ports:
- clk  input  1  system clock, same clock as the processor.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- load  input  1  capture strobe; driven by ssCtrl.
- data_in  input  8  value to display; driven by ssOutput.
- busy  output  1  conversion in progress; load is ignored while high.
- an  output  4  digit enables, active-low; an[0] = ones, an[3] = sign/leftmost.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset state (rst_n=0 at an edge): FSM=IDLE, busy=0, digit regs H/T/O=0, sign=0, refresh counter=0, digit index=0.
  - Resulting outputs: an=4'b1110, seg=7'b1000000 (shows "0").
  - Reset mid-conversion aborts the conversion; the previous display value is discarded (digits return to 0).
- FSM states: IDLE -> SHIFT -> COMMIT -> IDLE.
  - IDLE: load=1 at edge k latches data_in into the shift register, clears the BCD accumulator and bit counter, sets busy=1, goes to SHIFT.
  - SHIFT: one double-dabble step per cycle. Each step adds 3 to every BCD nibble >= 5, then shifts left by 1. Exactly 8 steps on edges k+1..k+8, then go to COMMIT.
  - COMMIT: at edge k+9, the BCD result (hundreds 0-2, tens, ones) loads the digit regs; busy=0; go to IDLE.
  - busy is high for exactly 9 cycles per conversion.
- load while busy=1 is ignored, including the COMMIT cycle. The earliest accepted new load is at edge k+10.
- Refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, digit index advances 0->1->2->3->0.
  - The counter is free-running and is not disturbed by load or commit.
- an: combinational one-cold decode of digit index. seg: combinational decode of the selected digit.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, minus=0111111
- Leading-zero blanking (LZ_BLANK=1):
  - Hundreds blank when H=0.
  - Tens blank when H=0 and T=0.
  - Ones is always shown.
- Digit 3 shows blank unless SS_SIGNED_EN applies.
- A commit updates the display immediately, mid-slot; no tearing protection is required.

Optional Feature:
- Macro: SS_SIGNED_EN.
- Defined:
  - data_in is two's complement. Magnitude = |data_in| as 8-bit unsigned, so 8'h80 -> 128.
  - Sign is latched at load and committed with the digits.
  - Digit 3 shows minus when the committed sign=1, blank otherwise.
- Undefined:
  - data_in is unsigned 0..255 and no sign register exists.
  - Digit 3 is always blank but still occupies its time slot, so duty cycle stays 1/4.

Decomposition:
- Package ss_pkg holds:
  - the segment code constants (SEG_0..SEG_9, SEG_BLANK, SEG_MINUS);
  - the FSM state typedef {IDLE, SHIFT, COMMIT};
  - NUM_DIGITS=4 and the BCD width constant (12).
- One sub-module: ss_bin2bcd.
  - Contains the FSM, shift/accumulator regs, bit counter, busy and done pulse.
  - The top keeps the digit regs, refresh counter, blanking and decode logic.

Test Plan:
- Reset, REFRESH_DIV=4, no load: an sequence 1110,1101,1011,0111, each held 4 cycles. seg is 1000000 on slot 0 and 1111111 on slots 1-3.
- load=1 with data_in=8'd255: busy high for 9 cycles. Afterwards digits H/T/O = 2/5/5, seg = 0100100, 0010010, 0010010 on slots 2/1/0.
- data_in=8'd7 with LZ_BLANK=1: slots 2 and 1 blank, slot 0 = 1111000. With LZ_BLANK=0: slots 2/1/0 = 0/0/7.
- Load 8'd100, then pulse load with 8'd42 on cycles 3 and 9 after acceptance: both pulses ignored, result 1/0/0. A load at cycle 10 with 8'd42 is accepted, result 4/2 with hundreds blank.
- Load 8'd200, assert rst_n=0 on cycle 5 for 1 cycle: busy=0, digits 0/0/0, an=1110 on the next cycle. The conversion is not resumed.
- SS_SIGNED_EN defined:
  - 8'h80 -> slot 3 minus, digits 1/2/8.
  - 8'hFF -> slot 3 minus, slot 0 = 1, slots 2/1 blank.
  - 8'd127 -> slot 3 blank.
